// File: rtl/fpu_fdiv_iter_if.sv
// Operand/result handshake bundle for the iterative FP divider.
interface fpu_fdiv_iter_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   rm;
  logic         kill;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   fflags;

  modport master (
    output in_valid, a, b, rm, kill, out_ready,
    input  in_ready, out_valid, result, fflags
  );

  modport slave (
    input  in_valid, a, b, rm, kill, out_ready,
    output in_ready, out_valid, result, fflags
  );
endinterface

// File: rtl/fpu_fdiv_iter.sv
// Iterative IEEE-754 divider: one restoring quotient bit per cycle, DAZ/FTZ,
// five static rounding modes, {NV,DZ,OF,UF,NX} flags and a flush input.
module fpu_fdiv_iter #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic          CLK,
  input  logic          nRST,
  fpu_fdiv_iter_if.slave io
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int Q  = FRAC_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int RW = FRAC_W + 3;
  localparam int CW = $clog2(Q + 1);

  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [EW-1:0] ONE     = EW'(1);
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EW-1:0] EMAX    = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [2:0]           rm_q, rm_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [FRAC_W:0]      mb_q, mb_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [Q-1:0]         quo_q, quo_d;
  logic [W-1:0]         res_q, res_d;
  logic [4:0]           flg_q, flg_d;

  // operand decode, subnormals read as zero
  logic               sa, sb, sign_in;
  logic [EXP_W-1:0]   ea, eb;
  logic [FRAC_W-1:0]  fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign {sa, ea, fa} = io.a;
  assign {sb, eb, fb} = io.b;
  assign sign_in = sa ^ sb;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == EXP_ONES) && (fa == '0);
  assign b_inf   = (eb == EXP_ONES) && (fb == '0);
  assign a_nan   = (ea == EXP_ONES) && (fa != '0);
  assign b_nan   = (eb == EXP_ONES) && (fb != '0);
  assign a_snan  = a_nan && !fa[FRAC_W-1];
  assign b_snan  = b_nan && !fb[FRAC_W-1];

  logic         spc_hit;
  logic [W-1:0] spc_res;
  logic [4:0]   spc_flg;

  always_comb begin
    spc_hit = 1'b1;
    spc_res = QNAN;
    spc_flg = '0;
    if (io.rm > 3'd4) begin
      spc_flg[4] = 1'b1;
    end else if (a_nan || b_nan) begin
      spc_flg[4] = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spc_flg[4] = 1'b1;
    end else if (a_inf) begin
      spc_res = {sign_in, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (b_zero) begin
      spc_res    = {sign_in, EXP_ONES, {FRAC_W{1'b0}}};
      spc_flg[3] = 1'b1;
    end else if (a_zero || b_inf) begin
      spc_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      spc_hit = 1'b0;
    end
  end

  // one restoring step
  logic [RW-1:0] mb_ext, rem_sub;
  logic          ge;

  assign mb_ext  = {2'b00, mb_q};
  assign ge      = (rem_q >= mb_ext);
  assign rem_sub = ge ? (rem_q - mb_ext) : rem_q;

  // normalise, round, range check
  logic                 norm, grd, stk, inc, cy, to_inf;
  logic [FRAC_W-1:0]    fpre, fr;
  logic signed [EW-1:0] en, er;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_flg;

  always_comb begin
    norm = quo_q[Q-1];
    fpre = norm ? quo_q[Q-2:2] : quo_q[Q-3:1];
    grd  = norm ? quo_q[1] : quo_q[0];
    stk  = (norm & quo_q[0]) | (rem_q != '0);
    en   = norm ? e_q : (e_q - ONE);
    unique case (rm_q)
      3'b000:  inc = grd & (stk | fpre[0]);
      3'b010:  inc = sign_q & (grd | stk);
      3'b011:  inc = !sign_q & (grd | stk);
      3'b100:  inc = grd;
      default: inc = 1'b0;
    endcase
    // a carry out of the fraction means the mantissa hit 2.0; fraction is already 0
    {cy, fr} = {1'b0, fpre} + {{FRAC_W{1'b0}}, inc};
    er       = cy ? (en + ONE) : en;
    to_inf   = (rm_q == 3'b000) || (rm_q == 3'b100) ||
               ((rm_q == 3'b011) && !sign_q) || ((rm_q == 3'b010) && sign_q);
    rnd_flg  = {4'b0000, grd | stk};
    rnd_res  = {sign_q, er[EXP_W-1:0], fr};
    if (er >= EMAX) begin
      rnd_flg = 5'b00101;
      rnd_res = to_inf ? {sign_q, EXP_ONES, {FRAC_W{1'b0}}}
                       : {sign_q, EXP_ONES - EXP_W'(1), {FRAC_W{1'b1}}};
    end else if (er < ONE) begin
      rnd_flg = 5'b00011;
      rnd_res = {sign_q, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    rm_d    = rm_q;
    e_d     = e_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      IDLE: if (io.in_valid && !io.kill) begin
        sign_d = sign_in;
        rm_d   = io.rm;
        if (spc_hit) begin
          res_d   = spc_res;
          flg_d   = spc_flg;
          state_d = DONE;
        end else begin
          e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          mb_d    = {1'b1, fb};
          rem_d   = {2'b01, fa};
          quo_d   = '0;
          cnt_d   = CW'(Q);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = {rem_sub[RW-2:0], 1'b0};
        quo_d = {quo_q[Q-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ROUND;
      end
      ROUND: begin
        res_d   = rnd_res;
        flg_d   = rnd_flg;
        state_d = DONE;
      end
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush wins over accept and output transfer
    if (io.kill) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = '0;
      flg_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      rm_q    <= '0;
      e_q     <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      rm_q    <= rm_d;
      e_q     <= e_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = res_q;
  assign io.fflags    = flg_q;
endmodule

// File: doc/fpu_fdiv_iter.md
# fpu_fdiv_iter

Parametrised iterative floating-point divider for the FPU execute stage, issued on `FUNCT_FDIV` under `OPCODE_FOP`. It generalises the half-precision field widths to any IEEE-754 binary format through `EXP_W`/`FRAC_W`. It computes one quotient bit per cycle behind a valid/ready handshake and supports all five static rounding modes. It returns IEEE result and accrued-exception flags, with a kill input for pipeline flush.

## Interface
- `EXP_W`, 5, exponent width (5 = half, 8 = single).
- `FRAC_W`, 10, fraction width; `W = 1+EXP_W+FRAC_W`.
- `CLK  in  1` — clock, rising edge.
- `nRST  in  1` — synchronous, active-low reset; the one clock and this reset polarity/synchronicity are fixed.
- `in_valid  in  1` — operands and rm are valid.
- `in_ready  out  1` — high exactly in IDLE.
- `a`, `b`  in  W — dividend, divisor.
- `rm  in  3` — RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100.
- `kill  in  1` — abort the operation in flight.
- `out_valid  out  1` — result valid.
- `out_ready  in  1` — consumer accepts.
- `result  out  W` — quotient.
- `fflags  out  5` — {NV, DZ, OF, UF, NX}.

## Operation
- **States:** IDLE, DIVIDE, ROUND, DONE.
- **IDLE:**
  - Accept on `in_valid && in_ready && !kill`; register a, b, rm and sign = `a.s ^ b.s`.
  - Subnormal inputs are flushed to signed zero (DAZ).
- **Special path** (IDLE→DONE directly):
  - Either input NaN → canonical qNaN (sign 0, exponent all ones, fraction MSB only; half 16'h7E00). NV is set if either input is an sNaN.
  - 0/0 or inf/inf → qNaN, NV.
  - finite nonzero / 0 → signed inf, DZ.
  - inf / finite → signed inf; 0 / nonzero, or finite / inf → signed zero; no flags.
  - rm in {101,110,111} → qNaN, NV. DYN is resolved upstream.
- **DIVIDE:**
  - Restoring division of `{1,fa}` by `{1,fb}`, producing Q = FRAC_W+3 quotient bits, MSB first, one bit per cycle. An iteration counter counts Q down to 0.
  - Exponent `e = ea − eb + (2^(EXP_W−1)−1)`, held signed in EXP_W+2 bits.
- **ROUND:**
  - If the quotient MSB is 0, shift left by 1 and decrement e.
  - Keep hidden bit + FRAC_W bits + guard bit. Sticky = OR(dropped bit, remainder≠0).
  - Round per rm; NX = guard | sticky.
  - A mantissa carry-out (2.0) shifts right by 1 and increments e.
  - Overflow (`e ≥ 2^EXP_W−1`) sets OF|NX. The result is signed inf for RNE/RMM, for RUP when positive, and for RDN when negative; otherwise it is max finite (`0x7BFF` magnitude for half).
  - Underflow (`e ≤ 0`) gives signed zero (FTZ) with UF|NX.
- **DONE:**
  - Hold `result`/`fflags` stable while `out_valid=1`.
  - On `out_ready` go to IDLE.
- **kill** (any state):
  - Next state is IDLE and `out_valid` goes low.
  - The result is discarded and no flags are emitted.
  - kill beats a simultaneous accept or `out_ready`.

## Timing
- **Reset:** state IDLE, `out_valid=0`, `result=0`, `fflags=0`, counter 0. `in_ready=1` from the first cycle after reset.
- **Reset mid-operation:** same as reset; nothing is emitted.
- **Special operands:** `out_valid` is high the cycle after the accept edge (latency 1).
- **Normal operands:** DIVIDE occupies Q cycles, ROUND 1 cycle, and `out_valid` rises FRAC_W+5 cycles after the accept edge (15 for half).
- **Handshake:**
  - Output transfers on the edge where `out_valid && out_ready`; `in_ready` rises the next cycle.
  - No overlap between operations: throughput is one operation per latency + 1 cycles minimum.
- **Stability:** inputs `a`/`b`/`rm` may change freely after acceptance.

## Test plan
- **Exact divide:** `3C00/3C00` RNE → `3C00`, fflags 0, `out_valid` exactly at cycle 15 after accept.
- **Rounding modes on 1/3:**
  - `3C00/4200` RNE → `3555`, NX.
  - Same operands RUP → `3556`, NX.
  - `BC00/4200` RDN → `B556`, NX.
- **Specials (latency 1):**
  - `3C00/0000` → `7C00`, DZ.
  - `0000/0000` → `7E00`, NV.
  - `7D00/3C00` (sNaN) → `7E00`, NV.
  - `7C00/4000` → `7C00`, no flags.
- **Overflow / underflow:**
  - `7BFF/1C00` RTZ → `7BFF`, OF|NX.
  - `7BFF/1C00` RNE → `7C00`, OF|NX.
  - `0400/4000` → `0000`, UF|NX.
- **Backpressure and kill:**
  - Hold `out_ready=0` for 5 cycles after `out_valid` → `result`/`fflags` stable and `in_ready=0`.
  - Assert kill in DIVIDE cycle 4 → IDLE next cycle, `out_valid` never rises.
  - Raise kill with `in_valid` in IDLE → no accept.
- **Reset mid-DIVIDE:** drive `nRST=0` one cycle → IDLE, all outputs 0. Then `4000/3C00` completes normally → `4000`.
